ad9228_capture: RTL

Frame builder directly downstream of the chip-readout trigger sequencer. Samples deserialized AD9228 data (4 channels × 12 bit) on every cycle the sequencer's `AD9228_read_en` is high. Wraps each readout burst in a header/trailer, buffers it in an internal FIFO, and streams 32-bit words on an AXI-Stream master toward the DMA. Runs entirely in the 40 MHz readout clock domain.

---
 rtl/ad9228_capture_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 46 ++++
 rtl/ad9228_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ad9228_capture_pkg.sv
// Shared types and constants for the AD9228 frame builder: FIFO entry layout,
// entry kinds, output-FSM states and the header/trailer magic words.
package ad9228_capture_pkg;

  typedef enum logic [1:0] {
    KIND_HDR  = 2'd0,
    KIND_DATA = 2'd1,
    KIND_TRL  = 2'd2
  } entry_kind_e;

  typedef enum logic {
    ST_W0 = 1'b0,
    ST_W1 = 1'b1
  } out_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hCAFE;
  localparam logic [15:0] TRL_MAGIC = 16'hE0F0;
  localparam int          ENTRY_W   = 50;

  typedef struct packed {
    entry_kind_e kind;
    logic [47:0] payload;
  } entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on
// rd_data whenever empty is low. Reports full, empty and free slot count.
module sync_fifo_fwft #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      free
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, count;

  assign count   = wptr - rptr;
  assign full    = (count == DEPTH_W);
  assign empty   = (count == '0);
  assign free    = DEPTH_W - count;
  assign rd_data = mem[rptr[AW-1:0]];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ad9228_capture.sv
// AD9228 frame builder: wraps each read_en burst in header/trailer entries,
// buffers them and streams two 32-bit words per entry on AXI-Stream.
module ad9228_capture
  import ad9228_capture_pkg::*;
#(
  parameter int NUM_DATA               = 1280,
  parameter int FIFO_DEPTH             = 2048,
  parameter int TRIGGER_COUNTER_LENGTH = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              read_en,
  input  logic [47:0]                       adc_data,
  input  logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_counter,
  input  logic                              clear,
  output logic [31:0]                       m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              overflow,
  output logic [15:0]                       dropped_frames,
  output logic                              busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TCW = (TRIGGER_COUNTER_LENGTH < 16) ? TRIGGER_COUNTER_LENGTH : 16;

  logic        en_q, en_q2;
  logic [47:0] data_q;
  logic        accepted, ovf_f, trunc_f;
  logic [15:0] frame_seq, sample_count, tc16;

  entry_t      wr_entry, rd_entry;
  logic        wr_en, rd_en, fifo_full, fifo_empty;
  logic [AW:0] fifo_free;

  logic frame_start, trl_wr, hdr_ok, data_room, under_limit;
  logic hdr_wr, data_wr, drop_frame, ovf_drop, trunc_drop;

  out_state_e state, state_nxt;

  assign tc16        = 16'(trigger_counter[TCW-1:0]);
  assign frame_start = read_en && !en_q;
  assign trl_wr      = en_q2 && !en_q && accepted;
  assign hdr_ok      = !fifo_full && (int'(fifo_free) >= 3);
  assign data_room   = int'(fifo_free) >= 2;
  assign under_limit = int'(sample_count) < NUM_DATA;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_en      = 1'b0;
    wr_entry   = '{kind: KIND_DATA, payload: data_q};
    hdr_wr     = 1'b0;
    data_wr    = 1'b0;
    drop_frame = 1'b0;
    ovf_drop   = 1'b0;
    trunc_drop = 1'b0;
    if (trl_wr) begin
      wr_en      = 1'b1;
      wr_entry   = '{kind: KIND_TRL,
                     payload: {frame_seq, 14'h0, trunc_f, ovf_f, sample_count}};
      drop_frame = frame_start;
    end else if (frame_start) begin
      if (hdr_ok) begin
        wr_en    = 1'b1;
        hdr_wr   = 1'b1;
        wr_entry = '{kind: KIND_HDR, payload: {frame_seq, HDR_MAGIC, tc16}};
      end else begin
        drop_frame = 1'b1;
      end
    end else if (en_q && accepted) begin
      // The last free slot stays reserved so the trailer can always be written.
      if (!under_limit)   trunc_drop = 1'b1;
      else if (data_room) begin
        wr_en   = 1'b1;
        data_wr = 1'b1;
      end else            ovf_drop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the delayed enables reset high so a read_en already high when
      // reset releases is not mistaken for a frame start.
      en_q           <= 1'b1;
      en_q2          <= 1'b1;
      data_q         <= '0;
      accepted       <= 1'b0;
      ovf_f          <= 1'b0;
      trunc_f        <= 1'b0;
      frame_seq      <= '0;
      sample_count   <= '0;
      overflow       <= 1'b0;
      dropped_frames <= '0;
    end else begin
      en_q   <= read_en;
      en_q2  <= en_q;
      data_q <= adc_data;
      if (trl_wr) begin
        accepted  <= 1'b0;
        frame_seq <= frame_seq + 16'd1;
      end
      if (hdr_wr) begin
        accepted     <= 1'b1;
        sample_count <= '0;
        ovf_f        <= 1'b0;
        trunc_f      <= 1'b0;
      end
      if (data_wr)    sample_count <= sample_count + 16'd1;
      if (ovf_drop)   ovf_f        <= 1'b1;
      if (trunc_drop) trunc_f      <= 1'b1;

      // A new event in the same cycle as clear survives the clear.
      if (ovf_drop)   overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
      if (drop_frame)
        dropped_frames <= clear ? 16'd1 :
                          (dropped_frames == 16'hFFFF) ? dropped_frames : dropped_frames + 16'd1;
      else if (clear)
        dropped_frames <= '0;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_W0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    if (m_axis_tvalid && m_axis_tready) begin
      if (state == ST_W0) begin
        state_nxt = ST_W1;
      end else begin
        state_nxt = ST_W0;
        rd_en     = 1'b1;
      end
    end
  end

  assign m_axis_tvalid = !fifo_empty;
  assign busy          = accepted || !fifo_empty;

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    if (!fifo_empty) begin
      if (rd_entry.kind == KIND_DATA)
        m_axis_tdata = (state == ST_W0) ?
          {4'h0, rd_entry.payload[23:12], 4'h0, rd_entry.payload[11:0]} :
          {4'h0, rd_entry.payload[47:36], 4'h0, rd_entry.payload[35:24]};
      else
        m_axis_tdata = (state == ST_W0) ? rd_entry.payload[31:0] :
          {(rd_entry.kind == KIND_TRL) ? TRL_MAGIC : 16'h0, rd_entry.payload[47:32]};
      m_axis_tlast = (state == ST_W1) && (rd_entry.kind == KIND_TRL);
    end
  end

endmodule
